// File: rtl/iot_event_reporter_if.sv
// Event bus between the device status fabric, the reporter and the monitor.
// master: reporter side (samples status/hold, drives the event pulses).
// slave:  consumer/driver side (drives status/hold, observes events).
interface iot_event_reporter_if #(
  parameter int N_DEV = 8,
  parameter int ID_W  = $clog2(N_DEV)
);
  logic             hold;
  logic [N_DEV-1:0] dev_status;
  logic             change;
  logic             on_off;
  logic [ID_W-1:0]  dev_id;
  logic             busy;

  modport master (
    input  hold, dev_status,
    output change, on_off, dev_id, busy
  );

  modport slave (
    output hold, dev_status,
    input  change, on_off, dev_id, busy
  );
endinterface

// File: rtl/iot_event_reporter.sv
// Device-side event producer for the active-device monitor.
// Each device owns a one-deep pending slot (on or off) fed by an edge
// detector; a round-robin arbiter issues one event per cycle as a
// registered (change, on_off, dev_id) pulse.

// Per-device edge detector and pending slot.
module iot_evt_cell (
  input  logic clk,
  input  logic rst,
  input  logic status,
  input  logic clr,       // this device's event is being issued this cycle
  output logic pend_on,
  output logic pend_off,
  output logic pend_nxt   // pending state after this edge, for busy
);
  logic status_q;
  logic rise, fall;
  logic on_c, off_c;
  logic on_n, off_n;

  assign rise = status & ~status_q;
  assign fall = ~status & status_q;

  // Grant clear lands first; an opposite edge then cancels or re-queues.
  always_comb begin
    on_c  = pend_on  & ~clr;
    off_c = pend_off & ~clr;
    on_n  = on_c;
    off_n = off_c;
    if (rise) begin
      if (off_c) off_n = 1'b0;
      else       on_n  = 1'b1;
    end else if (fall) begin
      if (on_c)  on_n  = 1'b0;
      else       off_n = 1'b1;
    end
  end

  assign pend_nxt = on_n | off_n;

  // Status history starts at 0 so devices high out of reset report as on.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_q <= 1'b0;
      pend_on  <= 1'b0;
      pend_off <= 1'b0;
    end else begin
      status_q <= status;
      pend_on  <= on_n;
      pend_off <= off_n;
    end
  end
endmodule

module iot_event_reporter #(
  parameter int N_DEV = 8,
  parameter int ID_W  = $clog2(N_DEV)
) (
  input  logic               clk,
  input  logic               rst,
  iot_event_reporter_if.master bus
);
  logic [N_DEV-1:0] pend_on, pend_off, pend_nxt, pend, clr;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_vld;
  logic             issue;

  logic             change_q, on_off_q, busy_q;
  logic [ID_W-1:0]  dev_id_q;

  iot_evt_cell u_cell [N_DEV-1:0] (
    .clk      (clk),
    .rst      (rst),
    .status   (bus.dev_status),
    .clr      (clr),
    .pend_on  (pend_on),
    .pend_off (pend_off),
    .pend_nxt (pend_nxt)
  );

  assign pend  = pend_on | pend_off;
  assign issue = gnt_vld & ~bus.hold;

  // Round-robin search: first pending device at rr_ptr, rr_ptr+1, ... wrapping.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_w;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_w   = '0;
    for (int k = 0; k < N_DEV; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_DEV) idx = idx - N_DEV;
      idx_w = idx[ID_W-1:0];
      if (!gnt_vld && pend[idx_w]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx_w;
      end
    end
  end

  // One-hot clear of the granted device's pending slot.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_DEV; i++)
      clr[i] = issue && (gnt_idx == ID_W'(i));
  end

  // Registered event pulse, pointer advance and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      change_q <= 1'b0;
      on_off_q <= 1'b0;
      dev_id_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= |pend_nxt;
      if (issue) begin
        change_q <= 1'b1;
        on_off_q <= pend_on[gnt_idx];
        dev_id_q <= gnt_idx;
        rr_ptr   <= (gnt_idx == ID_W'(N_DEV - 1)) ? '0 : gnt_idx + 1'b1;
      end else begin
        change_q <= 1'b0;
        on_off_q <= 1'b0;
      end
    end
  end

  assign bus.change = change_q;
  assign bus.on_off = on_off_q;
  assign bus.dev_id = dev_id_q;
  assign bus.busy   = busy_q;
endmodule
